// File: rtl/cpu_state_dumper.sv
// rtl/cpu_state_dumper.sv - end-of-run monitor that streams data-RAM and register-file contents
module cpu_state_dumper #(
  parameter int          DATA_W    = 32,
  parameter int          MEM_DEPTH = 512,
  parameter int          RF_DEPTH  = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          TIMEOUT   = 100000,
  parameter int          CNT_W     = 32,
  localparam int         MAW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int         RAW       = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rb_instr,
  input  logic              cpu_stop,
  output logic [MAW-1:0]    mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [RAW-1:0]    rf_addr,
  output logic              rf_rd,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        dout_tag,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              running,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {RUN, MEM_RD, MEM_OUT, SEP, RF_RD, RF_OUT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] dout_q;
  logic              fresh;
  logic              halt_req;
  logic              timeout_hit;
  logic              beat_taken;

  assign halt_req    = (rb_instr === HALT_WORD) | cpu_stop;
  assign timeout_hit = (TIMEOUT != 0) && (cycle_count == CNT_W'(TIMEOUT - 1));
  assign beat_taken  = dout_valid & dout_ready;

  // First output cycle of a word forwards the read data directly; dout_q holds it afterwards.
  assign dout = fresh ? ((dout_tag == 2'b01) ? rf_rdata : mem_rdata) : dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      running     <= 1'b1;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      dout_valid  <= 1'b0;
      mem_rd      <= 1'b0;
      rf_rd       <= 1'b0;
      dout_q      <= '0;
      fresh       <= 1'b0;
      dout_tag    <= 2'b00;
      mem_addr    <= '0;
      rf_addr     <= '0;
      cycle_count <= '0;
    end else begin
      fresh <= 1'b0;
      if (fresh) dout_q <= dout;
      case (state)
        RUN: begin
          if (halt_req) begin
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            mem_addr <= '0;
            mem_rd   <= 1'b1;
            state    <= MEM_RD;
          end else if (timeout_hit) begin
            timed_out <= 1'b1;
            mem_addr  <= '0;
            mem_rd    <= 1'b1;
            state     <= MEM_RD;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        MEM_RD: begin
          running    <= 1'b0;
          mem_rd     <= 1'b0;
          dout_tag   <= 2'b00;
          dout_valid <= 1'b1;
          fresh      <= 1'b1;
          state      <= MEM_OUT;
        end
        MEM_OUT: if (beat_taken) begin
          if (mem_addr == MAW'(MEM_DEPTH - 1)) begin
            // Separator goes out straight away, no read needed.
            dout_q   <= '0;
            dout_tag <= 2'b10;
            state    <= SEP;
          end else begin
            dout_valid <= 1'b0;
            mem_addr   <= mem_addr + 1'b1;
            mem_rd     <= 1'b1;
            state      <= MEM_RD;
          end
        end
        SEP: if (beat_taken) begin
          dout_valid <= 1'b0;
          rf_addr    <= '0;
          rf_rd      <= 1'b1;
          state      <= RF_RD;
        end
        RF_RD: begin
          rf_rd      <= 1'b0;
          dout_tag   <= 2'b01;
          dout_valid <= 1'b1;
          fresh      <= 1'b1;
          state      <= RF_OUT;
        end
        RF_OUT: if (beat_taken) begin
          dout_valid <= 1'b0;
          if (rf_addr == RAW'(RF_DEPTH - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rf_addr <= rf_addr + 1'b1;
            rf_rd   <= 1'b1;
            state   <= RF_RD;
          end
        end
        DONE: begin
          dout_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
